// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one single-port RAM between two requesters, with optional post-reset clear
//   clk, rst                 clock, synchronous active-high reset
//   init_done_o              high once the clear sequence has finished (or was skipped)
//   mN_req_i/wren_i/addr_i/data_i  requester N access request, held until granted
//   mN_gnt_o                 combinational grant; a transfer happens on req & gnt
//   mN_rvalid_o              rdata_o carries requester N's read data this cycle
//   rdata_o                  shared read data (RAM q)
//   ram_wren_o/address_o/data_o, ram_q_i   RAM control and read data
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int INIT_EN = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done_o,
    input  logic                  m0_req_i,
    input  logic                  m0_wren_i,
    input  logic [ADDR_W-1:0]     m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    input  logic                  m1_req_i,
    input  logic                  m1_wren_i,
    input  logic [ADDR_W-1:0]     m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  ram_wren_o,
    output logic [ADDR_W-1:0]     ram_address_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_q_i
);
    typedef enum logic {INIT, ARB} state_t;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);
    state_t              state_q, state_d;
    logic [ADDR_W:0]     init_cnt_q, init_cnt_d;
    logic                last_q, last_d;
    logic                rv0_q, rv0_d, rv1_q, rv1_d;
    logic                init_done_q, init_done_d;
    logic [ADDR_W-1:0]   addr_q;
    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        last_d        = last_q;
        m0_gnt_o      = 1'b0;
        m1_gnt_o      = 1'b0;
        ram_wren_o    = 1'b0;
        ram_address_o = addr_q;
        ram_data_o    = m0_data_i;
        init_done_d   = init_done_q;
        if (state_q == INIT) begin
            ram_wren_o    = 1'b1;
            ram_address_o = init_cnt_q[ADDR_W-1:0];
            ram_data_o    = INIT_VALUE;
            init_cnt_d    = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_CNT) begin
                state_d     = ARB;
                init_done_d = 1'b1;
            end
        end else begin
            init_done_d = 1'b1;
            // On contention the port that was not granted last wins
            m0_gnt_o = m0_req_i & (~m1_req_i | last_q);
            m1_gnt_o = m1_req_i & (~m0_req_i | ~last_q);
            last_d   = m0_gnt_o ? 1'b0 : m1_gnt_o ? 1'b1 : last_q;
            ram_wren_o    = (m0_gnt_o & m0_wren_i) | (m1_gnt_o & m1_wren_i);
            ram_address_o = m0_gnt_o ? m0_addr_i : m1_gnt_o ? m1_addr_i : addr_q;
            ram_data_o    = m1_gnt_o ? m1_data_i : m0_data_i;
        end
        rv0_d = m0_gnt_o & ~m0_wren_i;
        rv1_d = m1_gnt_o & ~m1_wren_i;
    end
    // addr_q keeps the RAM's registered read address stable while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (INIT_EN != 0) ? INIT : ARB;
            init_cnt_q  <= '0;
            last_q      <= 1'b1;
            rv0_q       <= 1'b0;
            rv1_q       <= 1'b0;
            init_done_q <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            last_q      <= last_d;
            rv0_q       <= rv0_d;
            rv1_q       <= rv1_d;
            init_done_q <= init_done_d;
            addr_q      <= ram_address_o;
        end
    end
    assign init_done_o = init_done_q;
    assign m0_rvalid_o = rv0_q;
    assign m1_rvalid_o = rv1_q;
    assign rdata_o     = ram_q_i;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a behavioural registered-address RAM
module tb_ram_arbiter;
    logic       clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
    logic       m0_req = 0, m0_wren = 0, m1_req = 0, m1_wren = 0;
    logic [7:0] m0_addr = 0, m0_data = 0, m1_addr = 0, m1_data = 0;
    logic       init_done, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_wren;
    logic [7:0] rdata, ram_address, ram_data, ram_q;
    logic       z1 = 1'b0;
    logic [7:0] z8 = 8'h00;
    logic       b_done, b_g0, b_g1, b_rv0, b_rv1, b_wren;
    logic [7:0] b_rdata, b_addr, b_data;
    logic [7:0] mem [256];
    logic [7:0] ra;
    logic [7:0] shadow [256];
    typedef struct {int cyc; logic [7:0] data;} exp_t;
    exp_t sb [2][$];
    int chk_cnt = 0, pass_cnt = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ram_arbiter u_dut (
        .clk(clk), .rst(rst), .init_done_o(init_done),
        .m0_req_i(m0_req), .m0_wren_i(m0_wren), .m0_addr_i(m0_addr), .m0_data_i(m0_data),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
        .m1_req_i(m1_req), .m1_wren_i(m1_wren), .m1_addr_i(m1_addr), .m1_data_i(m1_data),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .rdata_o(rdata),
        .ram_wren_o(ram_wren), .ram_address_o(ram_address), .ram_data_o(ram_data), .ram_q_i(ram_q)
    );

    ram_arbiter #(.INIT_EN(0)) u_dut_noinit (
        .clk(clk), .rst(rst2), .init_done_o(b_done),
        .m0_req_i(z1), .m0_wren_i(z1), .m0_addr_i(z8), .m0_data_i(z8),
        .m0_gnt_o(b_g0), .m0_rvalid_o(b_rv0),
        .m1_req_i(z1), .m1_wren_i(z1), .m1_addr_i(z8), .m1_data_i(z8),
        .m1_gnt_o(b_g1), .m1_rvalid_o(b_rv1), .rdata_o(b_rdata),
        .ram_wren_o(b_wren), .ram_address_o(b_addr), .ram_data_o(b_data), .ram_q_i(z8)
    );

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ra <= ram_address;
    end
    assign ram_q = mem[ra];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        logic [1:0] rv;
        exp_t e;
        rv = {m1_rvalid, m0_rvalid};
        for (int p = 0; p < 2; p++) begin
            if (rv[p]) begin
                if (sb[p].size() == 0) check($sformatf("m%0d_rvalid_unexpected", p), 64'(rv[p]), 64'd0);
                else begin
                    e = sb[p].pop_front();
                    check($sformatf("m%0d_rvalid_cycle", p), 64'(cyc), 64'(e.cyc));
                    check($sformatf("m%0d_rdata", p), 64'(rdata), 64'(e.data));
                end
            end else if (sb[p].size() != 0 && sb[p][0].cyc <= cyc) begin
                e = sb[p].pop_front();
                check($sformatf("m%0d_rvalid_missing", p), 64'(rv[p]), 64'd1);
            end
        end
    end

    task automatic step(input logic r0, w0, input logic [7:0] a0, d0,
                        input logic r1, w1, input logic [7:0] a1, d1,
                        input logic eg0, eg1);
        m0_req = r0; m0_wren = w0; m0_addr = a0; m0_data = d0;
        m1_req = r1; m1_wren = w1; m1_addr = a1; m1_data = d1;
        @(negedge clk);
        check("m0_gnt", 64'(m0_gnt), 64'(eg0));
        check("m1_gnt", 64'(m1_gnt), 64'(eg1));
        if (eg0) begin
            check("ram_address_m0", 64'(ram_address), 64'(a0));
            check("ram_wren_m0", 64'(ram_wren), 64'(w0));
            if (w0) begin
                check("ram_data_m0", 64'(ram_data), 64'(d0));
                shadow[a0] = d0;
            end else sb[0].push_back(exp_t'{cyc: cyc + 1, data: shadow[a0]});
        end
        if (eg1) begin
            check("ram_address_m1", 64'(ram_address), 64'(a1));
            check("ram_wren_m1", 64'(ram_wren), 64'(w1));
            if (w1) begin
                check("ram_data_m1", 64'(ram_data), 64'(d1));
                shadow[a1] = d1;
            end else sb[1].push_back(exp_t'{cyc: cyc + 1, data: shadow[a1]});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_check(input logic [7:0] held);
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        check("idle_gnt", 64'({m0_gnt, m1_gnt}), 64'd0);
        check("idle_wren", 64'(ram_wren), 64'd0);
        check("idle_addr_hold", 64'(ram_address), 64'(held));
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_init_done", 64'(init_done), 64'd0);
        check("reset_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'd0);
        rst = 0;
        m0_req = 1; m0_wren = 0; m0_addr = 8'h00;
        repeat (100) @(posedge clk);
        #1;
        check("mid_init_addr", 64'(ram_address), 64'd100);
        check("mid_init_done", 64'(init_done), 64'd0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            check($sformatf("clear_%0d", i), 64'({ram_wren, ram_address, ram_data, m0_gnt, init_done}),
                  64'({1'b1, 8'(i), 8'h00, 1'b0, 1'b0}));
            @(posedge clk); #1;
        end
        check("init_done_set", 64'(init_done), 64'd1);
        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
        step(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        step(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 1, 0);
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        idle_check(8'h10);
        step(1, 1, 8'h20, 8'h3C, 0, 0, 8'h00, 8'h00, 1, 0);
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1);
        idle_check(8'h20);
        for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 8'h00, 1, 1, 8'(i), 8'(8'h50 + i), 0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 8'h00, 1, 0, 8'(i), 8'h00, 0, 1);
        idle_check(8'h07);
        step(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 1, 0);
        step(1, 0, 8'h05, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1);
        step(1, 0, 8'h05, 8'h00, 1, 0, 8'h06, 8'h00, 1, 0);
        step(1, 0, 8'h10, 8'h00, 1, 0, 8'h06, 8'h00, 0, 1);
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        idle_check(8'h10);
        idle_check(8'h10);
        check("scoreboard_drained", 64'(sb[0].size() + sb[1].size()), 64'd0);
        @(negedge clk);
        check("noinit_reset_done", 64'(b_done), 64'd0);
        @(posedge clk); #1;
        rst2 = 0;
        @(negedge clk);
        check("noinit_pre_done", 64'(b_done), 64'd0);
        check("noinit_no_clear", 64'(b_wren), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("noinit_done", 64'(b_done), 64'd1);
        check("noinit_no_clear2", 64'(b_wren), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
